// File: rtl/serv_dbus_pkg.sv
// Shared encodings for the SERV data-bus interface: access sizes, FSM states,
// and the alignment rule used when misaligned-access trapping is enabled.
package serv_dbus_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_DONE = 2'b10,
        ST_TRAP = 2'b11
    } state_e;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        return ((size == SZ_H) && lsb[0]) || ((size == SZ_W) && (lsb != 2'b00));
    endfunction

endpackage

// File: rtl/serv_dbus_lane.sv
// Byte-lane logic: byte enables, write-data replication, read alignment and load sign bit.
// Latency: purely combinational. Backpressure: none, follows its inputs.
// Halves ignore lsb[0] and words ignore lsb entirely, so misaligned requests truncate.
module serv_dbus_lane
    import serv_dbus_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  lsb_i,
    input  logic [31:0] dat_i,
    input  logic [31:0] rdt_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wdat_o,
    output logic [31:0] rdat_o,
    output logic        sign_o
);

    logic [31:0] rsh;

    always_comb begin
        sel_o  = 4'b1111;
        wdat_o = dat_i;
        rsh    = rdt_i;
        sign_o = rdt_i[31];
        case (size_i)
            SZ_B: begin
                sel_o  = 4'b0001 << lsb_i;
                wdat_o = {4{dat_i[7:0]}};
                rsh    = rdt_i >> {lsb_i, 3'b000};
                sign_o = rsh[7];
            end
            SZ_H: begin
                sel_o  = 4'b0011 << {lsb_i[1], 1'b0};
                wdat_o = {2{dat_i[15:0]}};
                rsh    = rdt_i >> {lsb_i[1], 4'b0000};
                sign_o = rsh[15];
            end
            default: ;
        endcase
        rdat_o = rsh;
    end

endmodule

// File: rtl/serv_dbus_if.sv
// Bit-serial data-bus interface: shifts rs2 in, runs one bus cycle, streams load data out.
// Latency: cyc the cycle after i_req, o_rdy the cycle after ack. Backpressure: holds BUS until i_dbus_ack.
// SERV_DBUS_MISALIGN_TRAP_EN: misaligned requests pulse o_misalign instead of issuing a bus cycle.
module serv_dbus_if
    import serv_dbus_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_cnt_en,
    input  logic [W-1:0] i_rs2,
    input  logic         i_req,
    input  logic         i_we,
    input  logic [1:0]   i_size,
    input  logic         i_signed,
    input  logic [31:0]  i_adr,
    input  logic [1:0]   i_lsb,
    output logic [31:0]  o_dbus_adr,
    output logic [31:0]  o_dbus_dat,
    output logic [3:0]   o_dbus_sel,
    output logic         o_dbus_we,
    output logic         o_dbus_cyc,
    input  logic [31:0]  i_dbus_rdt,
    input  logic         i_dbus_ack,
    output logic         o_rdy,
    output logic         o_misalign,
    output logic [W-1:0] o_rd
);

    state_e      state_q, state_d;
    logic [31:0] dat_q, dat_d;
    logic [4:0]  cnt_q;
    logic [31:0] adr_q;
    logic [1:0]  size_q, lsb_q;
    logic        we_q, signed_q;
    logic        sign_q, sign_d;
    logic        start;
    logic        rd_bit;

    logic [3:0]  lane_sel;
    logic [31:0] lane_wdat, lane_rdat;
    logic        lane_sign;

    serv_dbus_lane u_lane (
        .size_i (size_q),
        .lsb_i  (lsb_q),
        .dat_i  (dat_q),
        .rdt_i  (i_dbus_rdt),
        .sel_o  (lane_sel),
        .wdat_o (lane_wdat),
        .rdat_o (lane_rdat),
        .sign_o (lane_sign)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_req) begin
`ifdef SERV_DBUS_MISALIGN_TRAP_EN
                    state_d = is_misaligned(i_size, i_lsb) ? ST_TRAP : ST_BUS;
`else
                    state_d = ST_BUS;
`endif
                end
            end
            ST_BUS:  if (i_dbus_ack) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign start = (state_q == ST_IDLE) && (state_d == ST_BUS);

    always_comb begin
        dat_d  = dat_q;
        sign_d = sign_q;
        if ((state_q == ST_IDLE) && i_cnt_en) begin
            dat_d = {i_rs2[0], dat_q[31:1]};
        end else if ((state_q == ST_BUS) && i_dbus_ack && !we_q) begin
            dat_d  = lane_rdat;
            sign_d = lane_sign;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            dat_q    <= '0;
            cnt_q    <= '0;
            adr_q    <= '0;
            size_q   <= SZ_B;
            lsb_q    <= '0;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            sign_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dat_q   <= dat_d;
            sign_q  <= sign_d;
            if (i_cnt_en) cnt_q <= cnt_q + 5'd1;
            if (start) begin
                adr_q    <= i_adr;
                size_q   <= i_size;
                lsb_q    <= i_lsb;
                we_q     <= i_we;
                signed_q <= i_signed;
            end
        end
    end

    // Past the access width, every write-back bit is the extension bit.
    always_comb begin
        rd_bit = dat_q[0];
        case (size_q)
            SZ_B:    if (cnt_q >= 5'd8)  rd_bit = signed_q & sign_q;
            SZ_H:    if (cnt_q >= 5'd16) rd_bit = signed_q & sign_q;
            default: ;
        endcase
    end

    assign o_rd       = {W{rd_bit}};
    assign o_dbus_cyc = (state_q == ST_BUS);
    assign o_rdy      = (state_q == ST_DONE);
    assign o_dbus_adr = adr_q;
    assign o_dbus_we  = we_q;
    assign o_dbus_sel = o_dbus_cyc ? lane_sel : 4'b0000;
    assign o_dbus_dat = lane_wdat;
`ifdef SERV_DBUS_MISALIGN_TRAP_EN
    assign o_misalign = (state_q == ST_TRAP);
`else
    assign o_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_serv_dbus_if.sv
// Bench for serv_dbus_if: directed scenarios plus randomized load/store traffic
// checked against an arithmetic model of byte lanes, alignment and extension.
module tb_serv_dbus_if;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_cnt_en;
    logic [0:0]  i_rs2;
    logic        i_req;
    logic        i_we;
    logic [1:0]  i_size;
    logic        i_signed;
    logic [31:0] i_adr;
    logic [1:0]  i_lsb;
    logic [31:0] o_dbus_adr;
    logic [31:0] o_dbus_dat;
    logic [3:0]  o_dbus_sel;
    logic        o_dbus_we;
    logic        o_dbus_cyc;
    logic [31:0] i_dbus_rdt;
    logic        i_dbus_ack;
    logic        o_rdy;
    logic        o_misalign;
    logic [0:0]  o_rd;

    int n_chk  = 0;
    int n_pass = 0;

    serv_dbus_if dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_cnt_en   (i_cnt_en),
        .i_rs2      (i_rs2),
        .i_req      (i_req),
        .i_we       (i_we),
        .i_size     (i_size),
        .i_signed   (i_signed),
        .i_adr      (i_adr),
        .i_lsb      (i_lsb),
        .o_dbus_adr (o_dbus_adr),
        .o_dbus_dat (o_dbus_dat),
        .o_dbus_sel (o_dbus_sel),
        .o_dbus_we  (o_dbus_we),
        .o_dbus_cyc (o_dbus_cyc),
        .i_dbus_rdt (i_dbus_rdt),
        .i_dbus_ack (i_dbus_ack),
        .o_rdy      (o_rdy),
        .o_misalign (o_misalign),
        .o_rd       (o_rd)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Reference model: plain arithmetic on byte offsets and access widths.
    function automatic logic [31:0] m_sel(input int sz, input int lsb);
        if (sz == 0) return 32'(2 ** lsb);
        if (sz == 1) return 32'(3 * (2 ** (lsb & 2)));
        return 32'd15;
    endfunction

    function automatic logic [31:0] m_wdat(input int sz, input logic [31:0] w);
        longint v;
        if (sz == 0) v = longint'(w % 256) * 64'h01010101;
        else if (sz == 1) v = longint'(w % 65536) * 64'h00010001;
        else v = longint'(w);
        return v[31:0];
    endfunction

    function automatic logic [31:0] m_load(input int sz, input int lsb, input bit sgn, input logic [31:0] rdt);
        longint v, nb;
        int     off;
        off = (sz == 0) ? lsb : (sz == 1) ? (lsb & 2) : 0;
        nb  = 8 * (2 ** sz);
        v   = longint'(rdt) / (64'd1 << (8 * off));
        v   = v % (64'd1 << nb);
        if (sgn && v >= (64'd1 << (nb - 1))) v = v - (64'd1 << nb);
        return v[31:0];
    endfunction

    task automatic shift_in(input logic [31:0] w);
        for (int i = 0; i < 32; i++) begin
            i_cnt_en = 1'b1;
            i_rs2    = w[i];
            step();
        end
        i_cnt_en = 1'b0;
        i_rs2    = 1'b0;
    endtask

    task automatic issue(input bit we, input int sz, input int lsb, input bit sgn, input logic [31:0] adr);
        i_req    = 1'b1;
        i_we     = we;
        i_size   = 2'(sz);
        i_lsb    = 2'(lsb);
        i_signed = sgn;
        i_adr    = adr;
        step();
        i_req    = 1'b0;
        i_we     = $urandom_range(0, 1);
        i_size   = 2'($urandom_range(0, 3));
        i_lsb    = 2'($urandom_range(0, 3));
        i_signed = $urandom_range(0, 1);
        i_adr    = $urandom;
    endtask

    task automatic do_store(input logic [31:0] adr, input int sz, input int lsb, input logic [31:0] w, input int waits);
        int lat;
        shift_in(w);
        issue(1'b1, sz, lsb, 1'b0, adr);
        lat = 1;
        check("st_cyc", 32'(o_dbus_cyc), 32'd1);
        check("st_we", 32'(o_dbus_we), 32'd1);
        check("st_adr", o_dbus_adr, adr);
        check("st_sel", 32'(o_dbus_sel), m_sel(sz, lsb));
        check("st_dat", o_dbus_dat, m_wdat(sz, w));
        for (int i = 0; i < waits; i++) begin
            step();
            lat++;
            check("st_wait_cyc", {o_dbus_cyc, o_rdy, o_dbus_sel}, {1'b1, 1'b0, 4'(m_sel(sz, lsb))});
            check("st_wait_dat", o_dbus_dat, m_wdat(sz, w));
        end
        i_dbus_ack = 1'b1;
        step();
        lat++;
        i_dbus_ack = 1'b0;
        check("st_rdy", {o_dbus_cyc, o_rdy, o_misalign}, 3'b010);
        check("st_lat", lat, waits + 2);
        check("st_dat_kept", o_dbus_dat, m_wdat(sz, w));
        step();
        check("st_rdy_pulse", 32'(o_rdy), 32'd0);
    endtask

    task automatic do_load(input logic [31:0] adr, input int sz, input int lsb, input bit sgn,
                           input logic [31:0] rdt, input int waits);
        logic [31:0] got;
        issue(1'b0, sz, lsb, sgn, adr);
        check("ld_cyc_we", {o_dbus_cyc, o_dbus_we}, 2'b10);
        check("ld_sel", 32'(o_dbus_sel), m_sel(sz, lsb));
        check("ld_adr", o_dbus_adr, adr);
        for (int i = 0; i < waits; i++) begin
            step();
            check("ld_wait", {o_dbus_cyc, o_rdy}, 2'b10);
        end
        i_dbus_ack = 1'b1;
        i_dbus_rdt = rdt;
        step();
        i_dbus_ack = 1'b0;
        i_dbus_rdt = $urandom;
        check("ld_rdy", {o_dbus_cyc, o_rdy, o_misalign}, 3'b010);
        step();
        for (int i = 0; i < 32; i++) begin
            i_cnt_en = 1'b1;
            i_rs2    = $urandom_range(0, 1);
            got[i]   = o_rd[0];
            step();
        end
        i_cnt_en = 1'b0;
        check("ld_rd", got, m_load(sz, lsb, sgn, rdt));
    endtask

    initial begin
        i_rst_n    = 1'b0;
        i_cnt_en   = 1'b0;
        i_rs2      = 1'b0;
        i_req      = 1'b0;
        i_we       = 1'b0;
        i_size     = 2'b00;
        i_signed   = 1'b0;
        i_adr      = '0;
        i_lsb      = '0;
        i_dbus_rdt = '0;
        i_dbus_ack = 1'b0;
        step();
        step();
        check("rst_ctl", {o_dbus_cyc, o_dbus_we, o_rdy, o_misalign, o_rd}, 5'b0);
        check("rst_sel", 32'(o_dbus_sel), 32'd0);
        check("rst_adr", o_dbus_adr, 32'd0);
        i_rst_n = 1'b1;
        step();

        do_store(32'h100, 2, 0, 32'hDEADBEEF, 3);
        do_store(32'h204, 0, 3, 32'h123456A5, 1);
        do_load(32'h300, 1, 2, 1'b1, 32'h80010000, 2);
        do_load(32'h300, 1, 2, 1'b0, 32'h80010000, 0);

        // Stray acks in IDLE must not start or finish anything.
        i_dbus_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stray_ack", {o_dbus_cyc, o_rdy}, 2'b00);
        end
        i_dbus_ack = 1'b0;
        do_store(32'h40, 2, 0, 32'h0BADF00D, 0);

        // Reset in the middle of a bus cycle.
        shift_in(32'hCAFEF00D);
        issue(1'b1, 2, 0, 1'b0, 32'h500);
        check("mid_cyc", 32'(o_dbus_cyc), 32'd1);
        i_rst_n = 1'b0;
        step();
        check("mid_rst", {o_dbus_cyc, o_rdy, o_dbus_sel}, 6'b0);
        i_rst_n = 1'b1;
        step();
        check("mid_no_rdy", {o_dbus_cyc, o_rdy}, 2'b00);
        do_store(32'h504, 1, 2, 32'h1357ACE1, 1);

        // Misaligned word at lsb=1.
`ifdef SERV_DBUS_MISALIGN_TRAP_EN
        issue(1'b1, 2, 1, 1'b0, 32'h600);
        check("mis_pulse", {o_misalign, o_dbus_cyc, o_rdy}, 3'b100);
        for (int i = 0; i < 3; i++) begin
            step();
            check("mis_quiet", {o_misalign, o_dbus_cyc, o_rdy}, 3'b000);
        end
`else
        do_store(32'h600, 2, 1, 32'h89ABCDEF, 1);
        check("mis_none", 32'(o_misalign), 32'd0);
`endif

        for (int k = 0; k < 24; k++) begin
            int sz, lsb, waits;
            sz    = $urandom_range(0, 2);
            lsb   = (sz == 0) ? $urandom_range(0, 3) : (sz == 1) ? 2 * $urandom_range(0, 1) : 0;
            waits = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1)
                do_store({$urandom, 2'b00} & 32'hFFFF_FFFC, sz, lsb, $urandom, waits);
            else
                do_load($urandom & 32'hFFFF_FFFC, sz, lsb, 1'($urandom_range(0, 1)), $urandom, waits);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
